ahci_afi_abort_seq: RTL and testbench
=====================================

Name: ahci_afi_abort_seq

Overview:
- Sequencer that takes an abort request from the AHCI DMA command layer and drives the AXI HP flusher (`axi_hp_abort`) through a safe abort.
- Order of operations:
  1. Fence the DMA engine so it issues no new address transfers.
  2. Wait until the AXI HP address channels have been quiet for a programmable time.
  3. Issue a one-cycle flush command and supervise it with a timeout and retries.
  4. Report success or failure.
- Sits between the AHCI DMA control FSM and the flusher, in the hclk domain.

Parameters:
- QUIET_CYCLES, 8: consecutive idle cycles (no DMA activity, no awvalid/arvalid) required before flushing; range 1..255.
- TIMEOUT_W, 16: width of the flush-timeout counter; timeout fires at 2^TIMEOUT_W-1 cycles.
- RETRY_MAX, 2: extra flush attempts after a timeout, before declaring failure; range 0..7.

Ports:
- hclk, in, 1: clock.
- hrst_n, in, 1: asynchronous active-low reset.
- abort_req, in, 1: pulse requesting abort.
- err_clr, in, 1: pulse; clears sticky abort_err.
- dma_busy, in, 1: DMA engine still generating/accepting beats.
- afi_awvalid, in, 1: monitored AXI HP write-address valid.
- afi_arvalid, in, 1: monitored AXI HP read-address valid.
- dma_stop, out, 1: fences DMA engine address issue.
- flush_abort, out, 1: one-cycle pulse to flusher abort input.
- flush_done, in, 1: flusher done pulse.
- flush_busy, in, 1: flusher busy.
- flush_dirty, in, 1: flusher dirty flag.
- flush_mismatch, in, 1: flusher axi_mismatch flag.
- abort_ack, out, 1: one-cycle pulse when the sequence completes (success or fail).
- abort_err, out, 1: sticky failure flag.
- abort_busy, out, 1: high in any state except IDLE.
- state_dbg, out, 3: current state encoding.

Behaviour:
- Reset values (async on hrst_n low): all outputs 0, state IDLE, counters 0.
- Reset mid-operation: immediate return to IDLE; dma_stop drops asynchronously.
- States and encodings: IDLE=0, FENCE=1, FLUSH=2, WAIT=3, CHECK=4, DONE=5, FAIL=6.
- IDLE:
  - abort_req → FENCE, retry count = 0.
  - dma_stop is registered: it rises the cycle after abort_req.
- FENCE:
  - dma_stop=1.
  - quiet counter increments while !dma_busy && !afi_awvalid && !afi_arvalid; clears to 0 on any activity.
  - When the counter reaches QUIET_CYCLES-1 with the current cycle also quiet → FLUSH.
  - Minimum FENCE dwell is QUIET_CYCLES cycles.
- FLUSH:
  - flush_abort=1 for exactly one cycle; timeout counter cleared; → WAIT.
- WAIT:
  - flush_done=1 → CHECK.
  - Otherwise the timeout counter increments; on all-ones:
    - retry count < RETRY_MAX: increment retry count, → FLUSH.
    - otherwise → FAIL.
  - If flush_done and timeout coincide, flush_done wins.
- CHECK (one cycle):
  - flush_mismatch || flush_dirty → FAIL.
  - otherwise → DONE.
- DONE: abort_ack=1 for one cycle; → IDLE; dma_stop drops on entry to IDLE.
- FAIL: abort_err set, abort_ack=1 for one cycle, → IDLE.
- dma_stop=1 in FENCE, FLUSH, WAIT, CHECK, DONE and FAIL.
- abort_err:
  - sticky; cleared by err_clr.
  - Setting takes priority if err_clr and FAIL coincide.
- abort_req outside IDLE: latched into one pending bit. On return to IDLE with pending set → FENCE the next cycle; pending cleared. Further requests while pending is set merge into the same bit.
- Flusher-state check: flush_busy already high when FLUSH would issue → skip the pulse and go straight to WAIT (no double abort).
- Arithmetic: counters saturate, never wrap; retry counter is 3 bits.

Optional Feature:
- Macro: AHCI_AFI_ABORT_STATS_EN.
- When defined, adds three outputs:
  - stat_aborts[15:0]: completed sequences.
  - stat_timeouts[15:0]: timeouts.
  - stat_fails[15:0]: entries to FAIL.
- All three counters saturate at 16'hffff, reset to 0 by hrst_n, and clear synchronously on err_clr.
- When undefined: the outputs are absent and no counter logic is present.

Decomposition:
- Shared include (ahci_afi_abort_defs.vh): state encoding localparams and default parameter values.
- One sub-module, ahci_afi_quiet_det: the quiet counter.
  - Inputs: activity, enable.
  - Output: quiet pulse.
  - Parameter: QUIET_CYCLES.

Test Plan:
- Clean abort, QUIET_CYCLES=8, no activity: abort_req at cycle 0 → dma_stop at 1, flush_abort at 9; flush_done at 12 → abort_ack at 14, abort_err=0, dma_stop=0 at 15.
- Activity in FENCE: afi_awvalid high at cycle 5 → quiet counter restarts; flush_abort not before cycle 14.
- Timeout, TIMEOUT_W=4, RETRY_MAX=2, flush_done never arrives → exactly 3 flush_abort pulses, then abort_err=1, abort_ack pulse; err_clr → abort_err=0.
- flush_done with flush_mismatch=1 → FAIL path: abort_err=1 and abort_ack pulse; no further retry.
- abort_req in WAIT → after DONE, one IDLE cycle, then a second FENCE; exactly two abort_ack pulses total.
- hrst_n low in WAIT → dma_stop, abort_busy and flush_abort all 0 asynchronously; state_dbg=0.

Source files
------------

// File: rtl/ahci_afi_abort_seq_pkg.sv
// Shared definitions for the AHCI AFI abort sequencer: state encodings,
// default parameter values, the flusher status bundle and a saturating helper.
package ahci_afi_abort_seq_pkg;

    localparam int QUIET_CYCLES_DEF = 8;
    localparam int TIMEOUT_W_DEF    = 16;
    localparam int RETRY_MAX_DEF    = 2;

    // Encodings are exported on state_dbg, so debug tooling depends on them.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FENCE = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_FAIL  = 3'd6;

    typedef struct packed {
        logic done;
        logic busy;
        logic dirty;
        logic mismatch;
    } flush_status_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ahci_afi_abort_seq_if.sv
// Signal bundle between the abort sequencer (master) and its environment:
// DMA control FSM, AXI HP monitor taps and the axi_hp_abort flusher.
// Statistics outputs exist only when AHCI_AFI_ABORT_STATS_EN is defined.
interface ahci_afi_abort_seq_if;

    logic       abort_req;
    logic       err_clr;
    logic       dma_busy;
    logic       afi_awvalid;
    logic       afi_arvalid;
    logic       dma_stop;
    logic       flush_abort;
    logic       flush_done;
    logic       flush_busy;
    logic       flush_dirty;
    logic       flush_mismatch;
    logic       abort_ack;
    logic       abort_err;
    logic       abort_busy;
    logic [2:0] state_dbg;
`ifdef AHCI_AFI_ABORT_STATS_EN
    logic [15:0] stat_aborts;
    logic [15:0] stat_timeouts;
    logic [15:0] stat_fails;
`endif

    modport master (
        input  abort_req, err_clr, dma_busy, afi_awvalid, afi_arvalid,
        input  flush_done, flush_busy, flush_dirty, flush_mismatch,
        output dma_stop, flush_abort, abort_ack, abort_err, abort_busy,
        output state_dbg
`ifdef AHCI_AFI_ABORT_STATS_EN
        , output stat_aborts, stat_timeouts, stat_fails
`endif
    );

    modport slave (
        output abort_req, err_clr, dma_busy, afi_awvalid, afi_arvalid,
        output flush_done, flush_busy, flush_dirty, flush_mismatch,
        input  dma_stop, flush_abort, abort_ack, abort_err, abort_busy,
        input  state_dbg
`ifdef AHCI_AFI_ABORT_STATS_EN
        , input stat_aborts, stat_timeouts, stat_fails
`endif
    );

endinterface

// File: rtl/ahci_afi_abort_seq_quiet.sv
// Quiet-window detector: counts consecutive idle cycles while enabled and
// pulses quiet on the QUIET_CYCLES-th consecutive idle cycle.
module ahci_afi_quiet_det #(
    parameter int QUIET_CYCLES = 8
) (
    input  logic hclk,
    input  logic hrst_n,
    input  logic enable,
    input  logic activity,
    output logic quiet
);

    localparam logic [7:0] LAST = 8'(QUIET_CYCLES - 1);

    logic [7:0] cnt_q;

    // The current cycle must itself be idle, so the window is cnt_q prior idle cycles plus this one.
    assign quiet = enable && !activity && (cnt_q == LAST);

    // NOTE: registers are written with <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            cnt_q <= '0;
        end else if (!enable || activity) begin
            cnt_q <= '0;
        end else if (cnt_q != 8'hff) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/ahci_afi_abort_seq.sv
// AHCI AFI abort sequencer: fences the DMA engine, waits for a quiet AXI HP
// address bus, then issues and supervises a flush of the axi_hp_abort flusher.
// Statistics counters are built only when AHCI_AFI_ABORT_STATS_EN is defined.
module ahci_afi_abort_seq
    import ahci_afi_abort_seq_pkg::*;
#(
    parameter int QUIET_CYCLES = QUIET_CYCLES_DEF,
    parameter int TIMEOUT_W    = TIMEOUT_W_DEF,
    parameter int RETRY_MAX    = RETRY_MAX_DEF
) (
    input  logic                 hclk,
    input  logic                 hrst_n,
    ahci_afi_abort_seq_if.master bus
);

    localparam logic [TIMEOUT_W-1:0] TMO_MAX   = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] TMO_LAST  = TMO_MAX - TIMEOUT_W'(1);
    localparam logic [2:0]           RETRY_LIM = 3'(RETRY_MAX);

    logic [2:0]           state_q;
    logic [2:0]           state_nxt;
    logic [2:0]           retry_q;
    logic [TIMEOUT_W-1:0] tmo_q;
    logic                 pending_q;
    logic                 abort_err_q;
    logic                 quiet;
    logic                 activity;
    logic                 fence_en;
    logic                 tmo_fire;
    flush_status_t        fst;

    assign fst = '{done:     bus.flush_done,
                   busy:     bus.flush_busy,
                   dirty:    bus.flush_dirty,
                   mismatch: bus.flush_mismatch};

    assign activity = bus.dma_busy | bus.afi_awvalid | bus.afi_arvalid;
    assign fence_en = (state_q == ST_FENCE);

    ahci_afi_quiet_det #(
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_quiet_det (
        .hclk     (hclk),
        .hrst_n   (hrst_n),
        .enable   (fence_en),
        .activity (activity),
        .quiet    (quiet)
    );

    // The counter would reach all-ones on this edge; a coincident flush_done takes precedence.
    assign tmo_fire = (state_q == ST_WAIT) && !fst.done && (tmo_q == TMO_LAST);

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.abort_req || pending_q) begin
                    state_nxt = ST_FENCE;
                end
            end
            ST_FENCE: begin
                if (quiet) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (fst.done) begin
                    state_nxt = ST_CHECK;
                end else if (tmo_fire) begin
                    state_nxt = (retry_q < RETRY_LIM) ? ST_FLUSH : ST_FAIL;
                end
            end
            ST_CHECK: state_nxt = (fst.mismatch || fst.dirty) ? ST_FAIL : ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_FAIL:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            retry_q <= '0;
        end else if (state_q == ST_IDLE && state_nxt == ST_FENCE) begin
            retry_q <= '0;
        end else if (tmo_fire && retry_q < RETRY_LIM && retry_q != 3'd7) begin
            retry_q <= retry_q + 3'd1;
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            tmo_q <= '0;
        end else if (state_q == ST_FLUSH) begin
            tmo_q <= '0;
        end else if (state_q == ST_WAIT && tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + TIMEOUT_W'(1);
        end
    end

    // Any request arriving outside IDLE folds into one bit; IDLE always consumes it.
    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            pending_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            pending_q <= 1'b0;
        end else if (bus.abort_req) begin
            pending_q <= 1'b1;
        end
    end

    // Set on FAIL entry so abort_err is already valid alongside abort_ack; setting beats err_clr.
    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            abort_err_q <= 1'b0;
        end else if (state_nxt == ST_FAIL || state_q == ST_FAIL) begin
            abort_err_q <= 1'b1;
        end else if (bus.err_clr) begin
            abort_err_q <= 1'b0;
        end
    end

    // Outputs decode the state register, so reset removes them without waiting for a clock.
    assign bus.dma_stop    = (state_q != ST_IDLE);
    assign bus.abort_busy  = (state_q != ST_IDLE);
    assign bus.flush_abort = (state_q == ST_FLUSH) && !fst.busy;
    assign bus.abort_ack   = (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign bus.abort_err   = abort_err_q;
    assign bus.state_dbg   = state_q;

`ifdef AHCI_AFI_ABORT_STATS_EN
    logic [15:0] stat_aborts_q;
    logic [15:0] stat_timeouts_q;
    logic [15:0] stat_fails_q;
    logic        fail_entry;

    assign fail_entry = (state_nxt == ST_FAIL) && (state_q != ST_FAIL);

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            stat_aborts_q   <= '0;
            stat_timeouts_q <= '0;
            stat_fails_q    <= '0;
        end else if (bus.err_clr) begin
            stat_aborts_q   <= '0;
            stat_timeouts_q <= '0;
            stat_fails_q    <= '0;
        end else begin
            if (bus.abort_ack) begin
                stat_aborts_q <= sat_inc16(stat_aborts_q);
            end
            if (tmo_fire) begin
                stat_timeouts_q <= sat_inc16(stat_timeouts_q);
            end
            if (fail_entry) begin
                stat_fails_q <= sat_inc16(stat_fails_q);
            end
        end
    end

    assign bus.stat_aborts   = stat_aborts_q;
    assign bus.stat_timeouts = stat_timeouts_q;
    assign bus.stat_fails    = stat_fails_q;
`endif

endmodule

// File: tb/tb_ahci_afi_abort_seq.sv
// Bench for ahci_afi_abort_seq: directed timing scenarios plus randomized
// traffic compared every cycle against a behavioural model of the abort rules.
module tb_ahci_afi_abort_seq;

    localparam int QC = 8;
    localparam int TW = 4;
    localparam int RM = 2;
    localparam int TMO_CYCLES = (1 << TW) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_FENCE = 1;
    localparam int P_FLUSH = 2;
    localparam int P_WAIT  = 3;
    localparam int P_CHECK = 4;
    localparam int P_DONE  = 5;
    localparam int P_FAIL  = 6;

    typedef struct packed {
        logic req;
        logic clr;
        logic busy;
        logic awv;
        logic arv;
        logic done;
        logic fbusy;
        logic dirty;
        logic mism;
    } stim_t;

    logic hclk = 1'b0;
    logic hrst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Reference model: phase plus spec-level counts.
    int m_phase;
    int m_quiet_run;
    int m_wait_age;
    int m_attempts;
    bit m_pend;
    bit m_err;
`ifdef AHCI_AFI_ABORT_STATS_EN
    int m_stat_ab;
    int m_stat_to;
    int m_stat_fl;
`endif

    ahci_afi_abort_seq_if bus ();

    ahci_afi_abort_seq #(
        .QUIET_CYCLES (QC),
        .TIMEOUT_W    (TW),
        .RETRY_MAX    (RM)
    ) dut (
        .hclk   (hclk),
        .hrst_n (hrst_n),
        .bus    (bus.master)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        bus.abort_req      = s.req;
        bus.err_clr        = s.clr;
        bus.dma_busy       = s.busy;
        bus.afi_awvalid    = s.awv;
        bus.afi_arvalid    = s.arv;
        bus.flush_done     = s.done;
        bus.flush_busy     = s.fbusy;
        bus.flush_dirty    = s.dirty;
        bus.flush_mismatch = s.mism;
    endtask

    function automatic logic [7:0] got_vec();
        return {bus.dma_stop, bus.flush_abort, bus.abort_ack, bus.abort_err,
                bus.abort_busy, bus.state_dbg};
    endfunction

    function automatic logic [7:0] exp_vec(input stim_t s);
        logic active;
        logic fa;
        logic ack;
        active = (m_phase != P_IDLE);
        fa     = (m_phase == P_FLUSH) && !s.fbusy;
        ack    = (m_phase == P_DONE) || (m_phase == P_FAIL);
        return {active, fa, ack, m_err, active, 3'(m_phase)};
    endfunction

    task automatic model_reset();
        m_phase     = P_IDLE;
        m_quiet_run = 0;
        m_wait_age  = 0;
        m_attempts  = 0;
        m_pend      = 1'b0;
        m_err       = 1'b0;
`ifdef AHCI_AFI_ABORT_STATS_EN
        m_stat_ab = 0;
        m_stat_to = 0;
        m_stat_fl = 0;
`endif
    endtask

    task automatic model_advance(input stim_t s);
        int nxt;
        bit tmo;
        bit was_ack;
        nxt     = m_phase;
        tmo     = 1'b0;
        was_ack = (m_phase == P_DONE) || (m_phase == P_FAIL);
        case (m_phase)
            P_IDLE: begin
                if (s.req || m_pend) begin
                    nxt         = P_FENCE;
                    m_attempts  = 1;
                    m_quiet_run = 0;
                end
            end
            P_FENCE: begin
                if (!s.busy && !s.awv && !s.arv) begin
                    m_quiet_run++;
                    if (m_quiet_run == QC) nxt = P_FLUSH;
                end else begin
                    m_quiet_run = 0;
                end
            end
            P_FLUSH: begin
                m_wait_age = 0;
                nxt        = P_WAIT;
            end
            P_WAIT: begin
                if (s.done) begin
                    nxt = P_CHECK;
                end else begin
                    m_wait_age++;
                    if (m_wait_age == TMO_CYCLES) begin
                        tmo = 1'b1;
                        if (m_attempts <= RM) begin
                            m_attempts++;
                            nxt = P_FLUSH;
                        end else begin
                            nxt = P_FAIL;
                        end
                    end
                end
            end
            P_CHECK: nxt = (s.mism || s.dirty) ? P_FAIL : P_DONE;
            default: nxt = P_IDLE;
        endcase
        if (m_phase == P_IDLE) m_pend = 1'b0;
        else if (s.req)        m_pend = 1'b1;
        if (nxt == P_FAIL || m_phase == P_FAIL) m_err = 1'b1;
        else if (s.clr)                         m_err = 1'b0;
`ifdef AHCI_AFI_ABORT_STATS_EN
        if (s.clr) begin
            m_stat_ab = 0;
            m_stat_to = 0;
            m_stat_fl = 0;
        end else begin
            if (was_ack && m_stat_ab < 65535) m_stat_ab++;
            if (tmo && m_stat_to < 65535) m_stat_to++;
            if (nxt == P_FAIL && m_stat_fl < 65535) m_stat_fl++;
        end
`else
        if (was_ack && tmo) m_attempts = m_attempts;
`endif
        m_phase = nxt;
    endtask

    // Entered at posedge+1: apply inputs, compare at +2, advance model, wait for next edge.
    task automatic step(input stim_t s, input string tag, output logic [7:0] obs);
        drive(s);
        #1;
        obs = got_vec();
        check($sformatf("%s_c%0d", tag, cyc), 32'(obs), 32'(exp_vec(s)));
`ifdef AHCI_AFI_ABORT_STATS_EN
        check($sformatf("%s_ab_c%0d", tag, cyc), 32'(bus.stat_aborts), 32'(m_stat_ab));
        check($sformatf("%s_to_c%0d", tag, cyc), 32'(bus.stat_timeouts), 32'(m_stat_to));
        check($sformatf("%s_fl_c%0d", tag, cyc), 32'(bus.stat_fails), 32'(m_stat_fl));
`endif
        model_advance(s);
        cyc++;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench watchdog");
    end

    initial begin
        stim_t      s;
        logic [7:0] obs;
        int         fa_cyc;
        int         ack_cyc;
        int         pulses;
        int         acks;
        int         ack1;
        logic       ack_err;
        logic       stop_a;
        logic       stop_b;
        logic [2:0] st_a;
        logic [2:0] st_b;
        bit         reqd;
        bit         reached;
        int         act_opts[3]  = '{0, 5, 25};
        int         done_opts[3] = '{0, 10, 50};
        int         p_act, p_done, p_bad, p_fb, p_req, p_clr;

        hrst_n = 1'b0;
        s = '0;
        drive(s);
        model_reset();
        #3;
        check("rst_outs", 32'(got_vec()), 32'd0);
        @(posedge hclk);
        #1;
        hrst_n = 1'b1;

        // Clean abort with fixed timing landmarks.
        fa_cyc = -1; ack_cyc = -1; ack_err = 1'b1; stop_a = 1'b0; stop_b = 1'b1;
        for (int k = 0; k < 18; k++) begin
            s = '0; s.req = (k == 0); s.done = (k == 12);
            step(s, "clean", obs);
            if (obs[6] && fa_cyc < 0) fa_cyc = k;
            if (obs[5] && ack_cyc < 0) begin ack_cyc = k; ack_err = obs[4]; end
            if (k == 1)  stop_a = obs[7];
            if (k == 15) stop_b = obs[7];
        end
        check("clean_stop_rise", 32'(stop_a), 32'd1);
        check("clean_fa_cyc", fa_cyc, 9);
        check("clean_ack_cyc", ack_cyc, 14);
        check("clean_err", 32'(ack_err), 32'd0);
        check("clean_stop_drop", 32'(stop_b), 32'd0);

        // Write-address activity mid-fence restarts the quiet window.
        fa_cyc = -1;
        for (int k = 0; k < 30; k++) begin
            s = '0; s.req = (k == 0); s.awv = (k == 5); s.done = (m_phase == P_WAIT);
            step(s, "act", obs);
            if (obs[6] && fa_cyc < 0) fa_cyc = k;
        end
        check("act_fa_cyc", fa_cyc, 14);

        // Flusher never answers: three attempts then failure.
        pulses = 0; acks = 0; ack_err = 1'b0;
        for (int k = 0; k < 90; k++) begin
            s = '0; s.req = (k == 0);
            step(s, "tmo", obs);
            if (obs[6]) pulses++;
            if (obs[5]) begin acks++; ack_err = obs[4]; end
        end
        check("tmo_pulses", pulses, 3);
        check("tmo_acks", acks, 1);
        check("tmo_err", 32'(ack_err), 32'd1);
        s = '0; s.clr = 1'b1;
        step(s, "tmo_clr", obs);
        s = '0;
        step(s, "tmo_post", obs);
        check("tmo_err_cleared", 32'(obs[4]), 32'd0);

        // flush_done on the cycle the timeout would fire wins.
        pulses = 0; acks = 0; ack_err = 1'b1;
        for (int k = 0; k < 30; k++) begin
            s = '0; s.req = (k == 0); s.done = (k == 10 + TMO_CYCLES - 1);
            step(s, "tie", obs);
            if (obs[6]) pulses++;
            if (obs[5]) begin acks++; ack_err = obs[4]; end
        end
        check("tie_pulses", pulses, 1);
        check("tie_acks", acks, 1);
        check("tie_err", 32'(ack_err), 32'd0);

        // Mismatch reported by the flusher fails without retry.
        pulses = 0; acks = 0; ack_err = 1'b0;
        for (int k = 0; k < 40; k++) begin
            s = '0; s.req = (k == 0); s.mism = 1'b1; s.done = (m_phase == P_WAIT);
            step(s, "mism", obs);
            if (obs[6]) pulses++;
            if (obs[5]) begin acks++; ack_err = obs[4]; end
        end
        check("mism_pulses", pulses, 1);
        check("mism_acks", acks, 1);
        check("mism_err", 32'(ack_err), 32'd1);
        s = '0; s.clr = 1'b1;
        step(s, "mism_clr", obs);

        // Second request during WAIT replays the whole sequence after one IDLE cycle.
        acks = 0; ack1 = -1; reqd = 1'b0; st_a = 3'd7; st_b = 3'd7;
        for (int k = 0; k < 60; k++) begin
            s = '0; s.req = (k == 0);
            if (m_phase == P_WAIT && !reqd) begin
                s.req = 1'b1;
                reqd  = 1'b1;
            end else begin
                s.done = (m_phase == P_WAIT);
            end
            step(s, "pend", obs);
            if (ack1 >= 0 && k == ack1 + 1) st_a = obs[2:0];
            if (ack1 >= 0 && k == ack1 + 2) st_b = obs[2:0];
            if (obs[5]) begin acks++; if (ack1 < 0) ack1 = k; end
        end
        check("pend_acks", acks, 2);
        check("pend_idle_gap", 32'(st_a), 32'd0);
        check("pend_refence", 32'(st_b), 32'd1);

        // Asynchronous reset while waiting for the flusher.
        reached = 1'b0;
        for (int k = 0; k < 30 && !reached; k++) begin
            s = '0; s.req = (k == 0);
            step(s, "rstw", obs);
            reached = (m_phase == P_WAIT);
        end
        check("rstw_reached", 32'(reached), 32'd1);
        check("rstw_pre_stop", 32'(bus.dma_stop), 32'd1);
        #2;
        hrst_n = 1'b0;
        #1;
        check("rstw_dma_stop", 32'(bus.dma_stop), 32'd0);
        check("rstw_busy", 32'(bus.abort_busy), 32'd0);
        check("rstw_flush_abort", 32'(bus.flush_abort), 32'd0);
        check("rstw_state", 32'(bus.state_dbg), 32'd0);
        model_reset();
        @(posedge hclk);
        #1;
        hrst_n = 1'b1;

        // Randomized traffic against the model.
        for (int sc = 0; sc < 40; sc++) begin
            p_act  = act_opts[$urandom_range(2)];
            p_done = done_opts[$urandom_range(2)];
            p_bad  = ($urandom_range(1) == 0) ? 0 : 30;
            p_fb   = ($urandom_range(1) == 0) ? 0 : 20;
            p_req  = ($urandom_range(1) == 0) ? 0 : 3;
            p_clr  = ($urandom_range(1) == 0) ? 0 : 5;
            for (int k = 0; k < 150; k++) begin
                s       = '0;
                s.req   = (k == 0) || ($urandom_range(99) < p_req);
                s.clr   = ($urandom_range(99) < p_clr);
                s.busy  = ($urandom_range(99) < p_act);
                s.awv   = ($urandom_range(99) < p_act);
                s.arv   = ($urandom_range(99) < p_act);
                s.done  = ((m_phase == P_WAIT) && ($urandom_range(99) < p_done))
                          || ($urandom_range(99) < 2);
                s.fbusy = ($urandom_range(99) < p_fb);
                s.dirty = ($urandom_range(99) < p_bad);
                s.mism  = ($urandom_range(99) < p_bad);
                step(s, $sformatf("rnd%0d", sc), obs);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
